// File: rtl/serial_sub_nbit.sv
// Bit-serial A - B, LSB first, one bit per clock through a single borrow flop; start/busy/done handshake.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf_out
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic              br;
    logic [CW-1:0]     cnt;
    logic              d;
    logic              br_nxt;
    logic [WIDTH-1:0]  res_nxt;
`ifdef SERIAL_SUB_OVF_EN
    logic              a_msb;
    logic              b_msb;
`endif

    // Difference bits enter the top of the minuend register as its bits leave the bottom,
    // so after WIDTH shifts a_sr holds the result and no separate result register is needed.
    assign d       = a_sr[0] ^ b_sr[0] ^ br;
    assign br_nxt  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign res_nxt = {d, a_sr[WIDTH-1:1]};

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            ovf_out    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_out <= 1'b0;
                    if (start_in) begin
                        a_sr     <= a_in;
                        b_sr     <= b_in;
                        br       <= 1'b0;
                        cnt      <= '0;
                        busy_out <= 1'b1;
                        state    <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb    <= a_in[WIDTH-1];
                        b_msb    <= b_in[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sr <= res_nxt;
                    b_sr <= b_sr >> 1;
                    br   <= br_nxt;
                    cnt  <= cnt + CW'(1);
                    // Outputs are loaded on the last bit edge so they are valid alongside done_out.
                    if (cnt == CW'(WIDTH - 1)) begin
                        state      <= DONE;
                        done_out   <= 1'b1;
                        diff_out   <= res_nxt;
                        borrow_out <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_out    <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                DONE: begin
                    done_out <= 1'b0;
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Scoreboard bench for serial_sub_nbit: stimulus pushes hand-computed results, a negedge monitor pops on done_out.
module tb_serial_sub_nbit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_sub_nbit #(.WIDTH(W)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .start_in  (start),
        .a_in      (a),
        .b_in      (b),
        .busy_out  (busy),
        .done_out  (done),
        .diff_out  (diff),
        .borrow_out(borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf_out   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   pushed   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor: every done_out cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done got diff=%0h expected no done", diff);
            end else begin
                e = q.pop_front();
                chk("diff", {24'h0, diff}, {24'h0, e.diff});
                chk("borrow", {31'h0, borrow}, {31'h0, e.borrow});
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf", {31'h0, ovf}, {31'h0, e.ovf});
`endif
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] ed, input logic eb, input logic eo);
        exp_t e;
        e.diff   = ed;
        e.borrow = eb;
        e.ovf    = eo;
        q.push_back(e);
        pushed++;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got no done expected done within 40 cycles");
        end
    endtask

    // Launch one operation from IDLE; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
        int n;
        n = 0;
        while ((busy !== 1'b0 || done !== 1'b0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        a     = av;
        b     = bv;
        push_exp(ed, eb, eo);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        chk("busy_after_start", {31'h0, busy}, 32'h1);
    endtask

    task automatic run(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb, input logic eo);
        int n;
        issue(av, bv, ed, eb, eo);
        wait_done(n);
        chk("latency", n, W);
        @(negedge clk);
        chk("done_single", {31'h0, done}, 32'h0);
        chk("busy_cleared", {31'h0, busy}, 32'h0);
        chk("diff_held", {24'h0, diff}, {24'h0, ed});
    endtask

    initial begin
        int n;
        int t[3];

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_diff", {24'h0, diff}, 32'h0);
        chk("rst_borrow", {31'h0, borrow}, 32'h0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", {31'h0, ovf}, 32'h0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);

        // A second start mid-operation must be ignored; the old result holds during SHIFT.
        issue(8'h0A, 8'h04, 8'h06, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        chk("diff_hold_in_shift", {24'h0, diff}, 32'hFE);
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("latency_ignored_start", n, W - 2);
        @(negedge clk);
        chk("done_single_ignored", {31'h0, done}, 32'h0);
        repeat (12) @(negedge clk);

        run(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
        run(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run(8'h01, 8'h80, 8'h81, 1'b1, 1'b1);

        // Reset mid-SHIFT aborts the operation without a done pulse.
        issue(8'h33, 8'h11, 8'h22, 1'b0, 1'b0);
        void'(q.pop_back());
        pushed--;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_diff", {24'h0, diff}, 32'h0);
        chk("abort_borrow", {31'h0, borrow}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run(8'h33, 8'h11, 8'h22, 1'b0, 1'b0);

        // Back-to-back with start held high: one result every WIDTH+2 cycles.
        for (int k = 0; k < 3; k++) push_exp(8'hFE, 1'b0, 1'b0);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h01;
        for (int k = 0; k < 3; k++) begin
            wait_done(n);
            t[k] = cyc;
            if (k == 2) start = 1'b0;
            @(negedge clk);
        end
        chk("b2b_period_0", t[1] - t[0], W + 2);
        chk("b2b_period_1", t[2] - t[1], W + 2);

        repeat (15) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("done_count", done_cnt, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
